image_downsampler: RTL

IMAGE_DOWNSAMPLER -- requirements
Module: image_downsampler

---
 rtl/image_downsampler.sv | 115 +++++++++++
 1 files changed

// File: rtl/image_downsampler.sv
// Downsamples a 128x128 8-bit grayscale raster to a 32x32 binary image by
// summing each 4x4 block and comparing the sum against THRESH.
module image_downsampler #(
    parameter int unsigned THRESH = 2040
) (
    input  logic          clk,
    input  logic          iRst_n,
    input  logic          sof,
    input  logic          pix_valid,
    input  logic [7:0]    pix_data,
    input  logic          img_ack,
    output logic [1023:0] image_out,
    output logic          image_ready,
    output logic          busy
);

    localparam int unsigned ACC_W = 12;
    localparam int unsigned N_BLK = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [6:0]       row;
    logic [6:0]       col;
    logic [ACC_W-1:0] acc [N_BLK];

    logic             accept;
    logic [4:0]       blk_col;
    logic [ACC_W-1:0] sum;
    logic             blk_end;
    logic             last_pix;
    logic [9:0]       bit_idx;

    // Pixel bookkeeping for the current raster position (sof handled separately)
    always_comb begin
        accept   = pix_valid && (state == CAPTURE);
        blk_col  = col[6:2];
        sum      = acc[blk_col] + ACC_W'(pix_data);
        blk_end  = (&row[1:0]) && (&col[1:0]);
        last_pix = (&row) && (&col);
        bit_idx  = {row[6:2], col[6:2]};
    end

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // sof wins in every state; img_ack only matters in READY
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (sof) state_nx = CAPTURE;
            end
            CAPTURE: begin
                if (sof)                        state_nx = CAPTURE;
                else if (pix_valid && last_pix) state_nx = READY;
            end
            READY: begin
                if (sof)          state_nx = CAPTURE;
                else if (img_ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            busy        <= 1'b0;
            image_ready <= 1'b0;
        end else begin
            busy        <= (state_nx == CAPTURE);
            image_ready <= (state_nx == READY);
        end
    end

    // Counters, per-column accumulators and the binarized image
    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            row       <= '0;
            col       <= '0;
            image_out <= '0;
            for (int unsigned i = 0; i < N_BLK; i++) acc[i] <= '0;
        end else if (sof) begin
            row       <= '0;
            image_out <= '0;
            for (int unsigned i = 0; i < N_BLK; i++) acc[i] <= '0;
            if (pix_valid) begin
                acc[0] <= ACC_W'(pix_data);
                col    <= 7'd1;
            end else begin
                col    <= '0;
            end
        end else if (accept) begin
            col <= col + 7'd1;
            if (&col) row <= row + 7'd1;
            if (blk_end) begin
                image_out[bit_idx] <= (sum >= ACC_W'(THRESH));
                acc[blk_col]       <= '0;
            end else begin
                acc[blk_col]       <= sum;
            end
        end
    end

endmodule
